// File: rtl/cpu_tg_pkg.sv
// Shared types for the CPU traffic generator: op table entry layout, FSM states, defaults.
package cpu_tg_pkg;

  localparam int TG_ADDR_W      = 16;
  localparam int TG_DATA_W      = 32;
  localparam int TG_TIMEOUT_DEF = 1024;

  typedef struct packed {
    logic                 is_write;
    logic [TG_ADDR_W-1:0] addr;
    logic [TG_DATA_W-1:0] wdata;
    logic                 chk_data;
    logic [TG_DATA_W-1:0] exp_data;
    logic                 chk_hit;
    logic                 exp_hit;
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } tg_state_t;

endpackage

// File: rtl/cpu_traffic_gen_if.sv
// Cache CPU port: the generator (master) drives requests, the cache (slave) answers with ready/hit/rdata.
interface cpu_traffic_gen_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) ();

  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic                  cpu_read;
  logic                  cpu_write;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic                  cpu_ready;
  logic                  cpu_hit;

  modport master (
    output cpu_addr, cpu_wdata, cpu_read, cpu_write,
    input  cpu_rdata, cpu_ready, cpu_hit
  );

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_read, cpu_write,
    output cpu_rdata, cpu_ready, cpu_hit
  );

endinterface

// File: rtl/cpu_tg_op_table.sv
// Op table: DEPTH entries of op_t, one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; the table is always programmed before use.
module cpu_tg_op_table
  import cpu_tg_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int IW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [IW-1:0] i_widx,
  input  op_t           i_wdat,
  input  logic [IW-1:0] i_ridx,
  output op_t           o_rdat
);

  op_t r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_widx] <= i_wdat;
  end

  assign o_rdat = r_mem[i_ridx];

endmodule

// File: rtl/cpu_traffic_gen.sv
// Replays a run-time programmed op table onto the cache CPU port, one request per ISSUE/WAIT pair,
// checking responses and keeping saturating hit/miss/error counters plus a response timeout.
module cpu_traffic_gen
  import cpu_tg_pkg::*;
#(
  parameter  int ADDR_WIDTH = TG_ADDR_W,
  parameter  int DATA_WIDTH = TG_DATA_W,
  parameter  int DEPTH      = 16,
  parameter  int TIMEOUT    = TG_TIMEOUT_DEF,
  parameter  int CNT_WIDTH  = 16,
  localparam int IW         = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 prog_we,
  input  logic [IW-1:0]        prog_idx,
  input  op_t                  prog_op,
  input  logic [IW:0]          n_ops,
  input  logic                 loop_en,
  input  logic                 start,
  input  logic                 stop,
  cpu_traffic_gen_if.master    cpu,
  output logic                 busy,
  output logic                 done,
  output logic [IW-1:0]        op_idx,
  output logic [CNT_WIDTH-1:0] hit_cnt,
  output logic [CNT_WIDTH-1:0] miss_cnt,
  output logic [CNT_WIDTH-1:0] err_cnt,
  output logic                 timeout_err
);

  localparam int TW = $clog2(TIMEOUT) + 1;

  tg_state_t            r_state, w_state_nxt;
  logic [IW-1:0]        r_op_idx;
  logic [IW:0]          r_n_ops;
  logic [IW:0]          w_n_ops_clamp;
  logic [TW-1:0]        r_timer;
  logic                 r_stop;
  logic                 r_timeout;
  logic [CNT_WIDTH-1:0] r_hit_cnt, r_miss_cnt, r_err_cnt;
  op_t                  w_op;
  logic                 w_active, w_issue, w_last, w_stop_seen, w_tmo, w_chk_err;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  cpu_tg_op_table #(.DEPTH(DEPTH)) u_table (
    .i_clk  (clk),
    .i_we   (prog_we && !busy),
    .i_widx (prog_idx),
    .i_wdat (prog_op),
    .i_ridx (r_op_idx),
    .o_rdat (w_op)
  );

  assign w_n_ops_clamp = (n_ops > (IW+1)'(DEPTH)) ? (IW+1)'(DEPTH) : n_ops;
  assign w_last        = ({1'b0, r_op_idx} == r_n_ops - (IW+1)'(1));
  assign w_stop_seen   = r_stop || stop;
  assign w_tmo         = (r_timer == TW'(TIMEOUT - 1));
  // Data compare only applies to reads; a hit mismatch and a data mismatch together still count once.
  assign w_chk_err     = (w_op.chk_hit && (cpu.cpu_hit != w_op.exp_hit)) ||
                         (!w_op.is_write && w_op.chk_data &&
                          (cpu.cpu_rdata != DATA_WIDTH'(w_op.exp_data)));

  always_comb begin
    w_state_nxt = r_state;
    w_active    = 1'b0;
    w_issue     = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = (w_n_ops_clamp == '0) ? ST_DONE : ST_ISSUE;
      end
      ST_ISSUE: begin
        busy        = 1'b1;
        w_active    = 1'b1;
        w_issue     = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        busy     = 1'b1;
        w_active = 1'b1;
        if (cpu.cpu_ready) begin
          if (w_stop_seen || (w_last && !loop_en)) w_state_nxt = ST_DONE;
          else                                     w_state_nxt = ST_ISSUE;
        end else if (w_tmo) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign cpu.cpu_addr  = w_active ? ADDR_WIDTH'(w_op.addr)  : '0;
  assign cpu.cpu_wdata = w_active ? DATA_WIDTH'(w_op.wdata) : '0;
  assign cpu.cpu_read  = w_issue && !w_op.is_write;
  assign cpu.cpu_write = w_issue &&  w_op.is_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_op_idx   <= '0;
      r_n_ops    <= '0;
      r_timer    <= '0;
      r_stop     <= 1'b0;
      r_timeout  <= 1'b0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_err_cnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_n_ops   <= w_n_ops_clamp;
            r_op_idx  <= '0;
            r_stop    <= 1'b0;
            r_timeout <= 1'b0;
            if (w_n_ops_clamp != '0) begin
              r_hit_cnt  <= '0;
              r_miss_cnt <= '0;
              r_err_cnt  <= '0;
            end
          end
        end
        ST_ISSUE: begin
          r_timer <= '0;
          if (stop) r_stop <= 1'b1;
        end
        ST_WAIT: begin
          if (stop) r_stop <= 1'b1;
          if (cpu.cpu_ready) begin
            if (cpu.cpu_hit) r_hit_cnt  <= sat_inc(r_hit_cnt);
            else             r_miss_cnt <= sat_inc(r_miss_cnt);
            if (w_chk_err)   r_err_cnt  <= sat_inc(r_err_cnt);
            if (w_state_nxt == ST_ISSUE) r_op_idx <= w_last ? '0 : r_op_idx + IW'(1);
          end else if (w_tmo) begin
            r_timeout <= 1'b1;
            r_err_cnt <= sat_inc(r_err_cnt);
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign op_idx      = r_op_idx;
  assign hit_cnt     = r_hit_cnt;
  assign miss_cnt    = r_miss_cnt;
  assign err_cnt     = r_err_cnt;
  assign timeout_err = r_timeout;

endmodule

// File: tb/tb_cpu_traffic_gen.sv
// Directed + randomized bench for cpu_traffic_gen with a cache responder and an op-level reference model.
module tb_cpu_traffic_gen;
  import cpu_tg_pkg::*;

  localparam int DEPTH = 16;
  localparam int IW    = 4;
  localparam int CW    = 16;
  localparam int TMO   = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, prog_we, loop_en, start, stop;
  logic [IW-1:0] prog_idx;
  op_t prog_op;
  logic [IW:0] n_ops;
  logic busy, done, timeout_err;
  logic [IW-1:0] op_idx;
  logic [CW-1:0] hit_cnt, miss_cnt, err_cnt;

  cpu_traffic_gen_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) cpu_if ();

  cpu_traffic_gen #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .DEPTH(DEPTH), .TIMEOUT(TMO), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_idx(prog_idx), .prog_op(prog_op),
    .n_ops(n_ops), .loop_en(loop_en), .start(start), .stop(stop), .cpu(cpu_if),
    .busy(busy), .done(done), .op_idx(op_idx), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
    .err_cnt(err_cnt), .timeout_err(timeout_err)
  );

  int errors = 0;
  int checks = 0;

  // Cache responder: answers each strobe after a random (or fixed) number of WAIT cycles.
  logic        rsp_ready = 1'b0, rsp_hit = 1'b0, man_ready = 1'b0, man_hit = 1'b0;
  logic [31:0] rsp_data = '0;
  logic        resp_en = 1'b0;
  int          fixed_lat = -1;
  int          rsp_n = 0;
  logic        tab_hit [512];
  logic [31:0] tab_dat [512];

  assign cpu_if.cpu_ready = rsp_ready | man_ready;
  assign cpu_if.cpu_hit   = man_ready ? man_hit : rsp_hit;
  assign cpu_if.cpu_rdata = rsp_data;

  initial begin
    forever begin
      @(negedge clk);
      while (resp_en && (cpu_if.cpu_read || cpu_if.cpu_write)) begin
        @(negedge clk);
        repeat ((fixed_lat >= 0) ? fixed_lat : $urandom_range(0, 3)) @(negedge clk);
        rsp_ready = 1'b1;
        rsp_hit   = tab_hit[rsp_n];
        rsp_data  = tab_dat[rsp_n];
        rsp_n++;
        @(negedge clk);
        rsp_ready = 1'b0;
      end
    end
  end

  // Monitor: logs every request strobe and done pulse.
  int          stb_cnt = 0, rise_cnt = 0, both_cnt = 0, done_cnt = 0;
  logic        prev_stb = 1'b0;
  logic [15:0] mon_addr [$];
  logic [31:0] mon_wdata [$];
  logic        mon_wr [$];
  int          mon_idx [$];

  always @(negedge clk) begin
    if (cpu_if.cpu_read || cpu_if.cpu_write) begin
      stb_cnt++;
      if (!prev_stb) rise_cnt++;
      mon_addr.push_back(cpu_if.cpu_addr);
      mon_wdata.push_back(cpu_if.cpu_wdata);
      mon_wr.push_back(cpu_if.cpu_write);
      mon_idx.push_back(int'(op_idx));
    end
    if (cpu_if.cpu_read && cpu_if.cpu_write) both_cnt++;
    if (done) done_cnt++;
    prev_stb = cpu_if.cpu_read || cpu_if.cpu_write;
  end

  op_t prog_mdl [DEPTH];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic op_t mk_op(input logic w, input logic [15:0] a, input logic [31:0] wd,
                                input logic cd, input logic [31:0] ed, input logic ch, input logic eh);
    op_t o;
    o.is_write = w; o.addr = a; o.wdata = wd;
    o.chk_data = cd; o.exp_data = ed; o.chk_hit = ch; o.exp_hit = eh;
    return o;
  endfunction

  task automatic prog(input int idx, input op_t o);
    prog_we = 1'b1; prog_idx = IW'(idx); prog_op = o;
    prog_mdl[idx] = o;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic kick(input int n, input logic lp);
    start = 1'b1; n_ops = (IW+1)'(n); loop_en = lp;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (done) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    check({tag, "_done_seen"}, seen, 1'b1);
  endtask

  task automatic wait_strobe(input string tag, input int max);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (cpu_if.cpu_read || cpu_if.cpu_write) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    check({tag, "_strobe_seen"}, seen, 1'b1);
  endtask

  // Reference model: op k of a run uses table entry k mod n_eff; counts follow the response rules.
  task automatic model_check(input string tag, input int rb, input int sb, input int nresp, input int neff);
    int eh, em, ee;
    op_t o;
    logic bad;
    eh = 0; em = 0; ee = 0;
    for (int k = 0; k < nresp; k++) begin
      o = prog_mdl[k % neff];
      if (tab_hit[rb+k]) eh++; else em++;
      bad = (o.chk_hit && (tab_hit[rb+k] != o.exp_hit)) ||
            (!o.is_write && o.chk_data && (tab_dat[rb+k] != o.exp_data));
      if (bad) ee++;
      check({tag, "_addr"}, mon_addr[sb+k], o.addr);
      check({tag, "_rw"}, mon_wr[sb+k], o.is_write);
      check({tag, "_idx"}, mon_idx[sb+k], k % neff);
      if (o.is_write) check({tag, "_wdata"}, mon_wdata[sb+k], o.wdata);
    end
    check({tag, "_nresp"}, rsp_n - rb, nresp);
    check({tag, "_nstb"}, stb_cnt - sb, nresp);
    check({tag, "_hit"}, hit_cnt, eh);
    check({tag, "_miss"}, miss_cnt, em);
    check({tag, "_err"}, err_cnt, ee);
  endtask

  initial begin
    int rb, sb, db, rise_b, cnt, nreq, neff, lcl;
    logic seen;
    rst = 1'b1; prog_we = 1'b0; prog_idx = '0; prog_op = '0; n_ops = '0;
    loop_en = 1'b0; start = 1'b0; stop = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_wr", {cpu_if.cpu_read, cpu_if.cpu_write}, 0);
    check("rst_addr", cpu_if.cpu_addr, 0);
    check("rst_cnts", {hit_cnt, miss_cnt, err_cnt}, 0);
    check("rst_tmo_idx", {timeout_err, op_idx}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Six-op sequence, entry 0 written in the same cycle as start.
    resp_en = 1'b1;
    prog(0, mk_op(0, 16'hBEEF, 0, 0, 0, 0, 0));
    prog(1, mk_op(0, 16'h0004, 0, 0, 0, 0, 0));
    prog(2, mk_op(1, 16'h0008, 32'h11111111, 0, 0, 0, 0));
    prog(3, mk_op(0, 16'h0400, 0, 0, 0, 0, 0));
    prog(4, mk_op(0, 16'h0000, 0, 0, 0, 0, 0));
    prog(5, mk_op(0, 16'h0400, 0, 0, 0, 0, 0));
    rb = rsp_n; sb = stb_cnt; db = done_cnt; rise_b = rise_cnt;
    for (int k = 0; k < 6; k++) begin
      tab_hit[rb+k] = (k == 1 || k == 2 || k == 5);
      tab_dat[rb+k] = $urandom;
    end
    prog_mdl[0] = mk_op(0, 16'h0000, 0, 0, 0, 0, 0);
    prog_we = 1'b1; prog_idx = '0; prog_op = prog_mdl[0];
    start = 1'b1; n_ops = 5'd6; loop_en = 1'b0;
    @(negedge clk);
    prog_we = 1'b0; start = 1'b0;
    wait_done("seq6", 200);
    @(negedge clk);
    model_check("seq6", rb, sb, 6, 6);
    check("seq6_hit3", hit_cnt, 3);
    check("seq6_miss3", miss_cnt, 3);
    check("seq6_rises", rise_cnt - rise_b, 6);
    check("seq6_both", both_cnt, 0);
    check("seq6_done1", done_cnt - db, 1);
    check("seq6_busy", busy, 0);

    // Hit and data mismatch on the same op count once.
    prog(1, mk_op(0, 16'h0004, 0, 1, 32'hDEADBEEF, 1, 1));
    rb = rsp_n; sb = stb_cnt;
    for (int k = 0; k < 6; k++) begin
      tab_hit[rb+k] = (k == 1) ? 1'b0 : 1'b1;
      tab_dat[rb+k] = (k == 1) ? 32'h12345678 : $urandom;
    end
    kick(6, 0);
    wait_done("dbl", 200);
    @(negedge clk);
    check("dbl_err1", err_cnt, 1);
    model_check("dbl", rb, sb, 6, 6);

    // Random tables and responses; first pass uses n_ops above DEPTH.
    for (int rep = 0; rep < 3; rep++) begin
      for (int e = 0; e < DEPTH; e++)
        prog(e, mk_op($urandom_range(0, 1), 16'($urandom), $urandom, $urandom_range(0, 1),
                      $urandom, $urandom_range(0, 1), $urandom_range(0, 1)));
      nreq = (rep == 0) ? 20 : $urandom_range(1, 31);
      neff = (nreq > DEPTH) ? DEPTH : nreq;
      rb = rsp_n; sb = stb_cnt;
      for (int k = 0; k < neff; k++) begin
        tab_hit[rb+k] = 1'($urandom_range(0, 1));
        tab_dat[rb+k] = $urandom_range(0, 1) ? prog_mdl[k].exp_data : $urandom;
      end
      kick(nreq, 0);
      wait_done("rnd", 400);
      @(negedge clk);
      model_check("rnd", rb, sb, neff, neff);
    end

    // Timeout: no response ever; DONE follows 16 WAIT cycles.
    resp_en = 1'b0;
    prog(0, mk_op(0, 16'h0040, 0, 0, 0, 0, 0));
    kick(1, 0);
    wait_strobe("tmo", 20);
    cnt = 0; seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cnt++;
      if (done) begin seen = 1'b1; break; end
    end
    check("tmo_done_seen", seen, 1);
    check("tmo_cycles", cnt, 17);
    check("tmo_flag", timeout_err, 1);
    check("tmo_err", err_cnt, 1);
    check("tmo_busy", busy, 0);

    // Looping with stop during the 5th op.
    resp_en = 1'b1;
    prog(0, mk_op(0, 16'h0100, 0, 0, 0, 0, 0));
    prog(1, mk_op(1, 16'h0104, 32'hA5A5A5A5, 0, 0, 0, 0));
    prog(2, mk_op(0, 16'h0108, 0, 0, 0, 0, 0));
    rb = rsp_n; sb = stb_cnt;
    for (int k = 0; k < 8; k++) begin
      tab_hit[rb+k] = 1'($urandom_range(0, 1));
      tab_dat[rb+k] = $urandom;
    end
    kick(3, 1);
    check("loop_tmo_clr", timeout_err, 0);
    lcl = 0; seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (done) begin seen = 1'b1; break; end
      stop = 1'b0;
      if (cpu_if.cpu_read || cpu_if.cpu_write) begin
        lcl++;
        if (lcl == 5) stop = 1'b1;
      end
      @(negedge clk);
    end
    stop = 1'b0;
    check("loop_done_seen", seen, 1);
    @(negedge clk);
    model_check("loop", rb, sb, 5, 3);

    // n_ops = 0 finishes at once without requests.
    sb = stb_cnt;
    kick(0, 0);
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    @(negedge clk);
    check("zero_done_pulse", done, 0);
    check("zero_nstb", stb_cnt - sb, 0);

    // start and prog_we while busy are ignored.
    fixed_lat = 6;
    prog(0, mk_op(0, 16'h1234, 0, 0, 0, 0, 0));
    sb = stb_cnt; db = done_cnt;
    kick(1, 0);
    wait_strobe("ign", 20);
    @(negedge clk);
    prog_we = 1'b1; prog_idx = '0; prog_op = mk_op(0, 16'h5678, 0, 0, 0, 0, 0);
    start = 1'b1; n_ops = 5'd1;
    @(negedge clk);
    prog_we = 1'b0; start = 1'b0;
    wait_done("ign", 50);
    repeat (8) @(negedge clk);
    check("ign_nstb", stb_cnt - sb, 1);
    check("ign_ndone", done_cnt - db, 1);
    fixed_lat = -1;
    sb = stb_cnt;
    kick(1, 0);
    wait_done("readback", 50);
    @(negedge clk);
    check("readback_addr", mon_addr[sb], 16'h1234);

    // Reset during WAIT; a late response is ignored.
    resp_en = 1'b0;
    kick(1, 0);
    wait_strobe("rstw", 20);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstw_busy", busy, 0);
    check("rstw_strobes", {cpu_if.cpu_read, cpu_if.cpu_write}, 0);
    check("rstw_addr", {cpu_if.cpu_addr, cpu_if.cpu_wdata}, 0);
    check("rstw_outs", {done, timeout_err, op_idx}, 0);
    man_ready = 1'b1; man_hit = 1'b1;
    @(negedge clk);
    man_ready = 1'b0;
    @(negedge clk);
    check("rstw_cnts", {hit_cnt, miss_cnt, err_cnt}, 0);
    check("rstw_idle", {busy, done}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
